// File: rtl/lzw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lzw_pkg
// Description : Shared constants and types for the LZW capture path.
// Revision    : 1.0 - initial release
// ============================================================================
package lzw_pkg;

    localparam int CODE_WIDTH = 12;

    typedef enum logic [1:0] {
        SINK_IDLE    = 2'd0,
        SINK_CAPTURE = 2'd1,
        SINK_DONE    = 2'd2
    } sink_state_t;

endpackage : lzw_pkg
`default_nettype wire

// File: rtl/sink_ram.sv
`default_nettype none
// ============================================================================
// Module      : sink_ram
// Description : Simple dual-port RAM, one write port and one registered
//               read-first read port, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sink_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_q
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    // Read and write in the same block: a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_q <= r_mem[rd_addr];
    end

    assign rd_q = r_q;

endmodule : sink_ram
`default_nettype wire

// File: rtl/code_sink.sv
`default_nettype none
// ============================================================================
// Module      : code_sink
// Description : Terminates the LZW code stream: captures code words into RAM,
//               counts them and flags end of stream. Optional XOR checksum
//               output when CODE_SINK_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module code_sink
    import lzw_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = CODE_WIDTH,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_eof,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
`ifdef CODE_SINK_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);

    sink_state_t           r_state;
    sink_state_t           w_state_nxt;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_rd_live;
    logic                  w_start;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_ram_q;

    assign w_start  = (r_state == SINK_IDLE) && cs;
    assign in_ready = (r_state == SINK_CAPTURE) && (r_count < c_depth);
    assign w_wr     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SINK_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping cs aborts a capture even if eof arrives in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SINK_IDLE:    if (cs) w_state_nxt = SINK_CAPTURE;
            SINK_CAPTURE: begin
                if (!cs)         w_state_nxt = SINK_IDLE;
                else if (in_eof) w_state_nxt = SINK_DONE;
            end
            SINK_DONE:    if (!cs) w_state_nxt = SINK_IDLE;
            default:      w_state_nxt = SINK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_live  <= 1'b0;
        end else begin
            r_rd_live <= 1'b1;
            if (w_start) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_count <= r_count + 1'b1;
                end
                if ((r_state == SINK_CAPTURE) && in_valid && !in_ready) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

`ifdef CODE_SINK_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_wr) begin
            r_checksum <= r_checksum ^ in_data;
        end
    end

    assign checksum = r_checksum;
`endif

    sink_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we      (w_wr),
        .wr_addr (r_count[ADDR_WIDTH-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_q    (w_ram_q)
    );

    // RAM has no reset; mask its output until the first post-reset read lands.
    assign rd_data  = r_rd_live ? w_ram_q : '0;
    assign count    = r_count;
    assign done     = (r_state == SINK_DONE);
    assign overflow = r_overflow;

endmodule : code_sink
`default_nettype wire
